// File: rtl/uart_hex_tx_sequencer.sv
// Prints a binary word as uppercase ASCII hex through an 8N1 UART transmitter,
// most significant nibble first, optionally followed by CR LF.
module uart_hex_tx_sequencer #(
  parameter int NUM_NIBBLES = 8,
  parameter int APPEND_CRLF = 1
) (
  input  logic                     i_Clock,
  input  logic                     i_Rst_n,
  input  logic                     i_Start,
  input  logic [4*NUM_NIBBLES-1:0] i_Data,
  input  logic                     i_Tx_Active,
  input  logic                     i_Tx_Done,
  output logic                     o_Tx_DV,
  output logic [7:0]               o_Tx_Byte,
  output logic                     o_Busy,
  output logic                     o_Done
);

  localparam int DW     = 4 * NUM_NIBBLES;
  localparam int NCHARS = NUM_NIBBLES + 2 * APPEND_CRLF;
  localparam int IW     = $clog2(NCHARS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHARS - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_FINISH    = 2'd3;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] ch;
    if (nib < 4'd10) begin
      ch = 8'h30 + {4'h0, nib};
    end else begin
      ch = 8'h37 + {4'h0, nib};
    end
    return ch;
  endfunction

  function automatic logic [7:0] char_at(input logic [DW-1:0] data, input logic [IW-1:0] k);
    logic [DW-1:0] shifted;
    logic [7:0]    ch;
    int            ki;
    ki      = int'(k);
    shifted = {DW{1'b0}};
    if (ki < NUM_NIBBLES) begin
      shifted = data >> (4 * (NUM_NIBBLES - 1 - ki));
      ch      = hex_ascii(shifted[3:0]);
    end else if (ki == NUM_NIBBLES) begin
      ch = 8'h0D;
    end else begin
      ch = 8'h0A;
    end
    return ch;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic          tx_dv_q, tx_dv_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tx_done_prev_q, tx_done_prev_d;
  logic          tx_ready_s;
  logic          done_rise_s;

  // Ready excludes the transmitter's cleanup and trailing done cycles.
  assign tx_ready_s  = ~i_Tx_Active & ~i_Tx_Done;
  assign done_rise_s = i_Tx_Done & ~tx_done_prev_q;

  // Next-state and output computation for the character sequencer.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    data_d         = data_q;
    tx_dv_d        = 1'b0;
    tx_byte_d      = tx_byte_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    tx_done_prev_d = i_Tx_Done;
    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          data_d  = i_Data;
          idx_d   = {IW{1'b0}};
          busy_d  = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (tx_ready_s) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = char_at(data_q, idx_q);
          state_d   = ST_WAIT_DONE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_DONE: begin
        if (done_rise_s) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_FINISH;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q        <= ST_IDLE;
      idx_q          <= {IW{1'b0}};
      data_q         <= {DW{1'b0}};
      tx_dv_q        <= 1'b0;
      tx_byte_q      <= 8'h00;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      tx_done_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      data_q         <= data_d;
      tx_dv_q        <= tx_dv_d;
      tx_byte_q      <= tx_byte_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      tx_done_prev_q <= tx_done_prev_d;
    end
  end

  assign o_Tx_DV   = tx_dv_q;
  assign o_Tx_Byte = tx_byte_q;
  assign o_Busy    = busy_q;
  assign o_Done    = done_q;

endmodule

// File: tb/tb_uart_hex_tx_sequencer.sv
// Bench for uart_hex_tx_sequencer: two configurations, each driving a behavioural
// 8N1 transmitter whose serial line is decoded and compared with a word-level model.
module tb_uart_hex_tx_sequencer;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  start = 2'b00;
  logic [31:0] data0 = 32'h0;
  logic [7:0]  data1 = 8'h0;

  logic [1:0]  tx_active = 2'b00;
  logic [1:0]  tx_done = 2'b00;
  logic [1:0]  tx_serial = 2'b11;
  wire         tx_dv0, tx_dv1, busy0, busy1, done0, done1;
  wire  [7:0]  tx_byte0, tx_byte1;

  int          n_checks = 0;
  int          n_errors = 0;

  logic [7:0]  exp_dv_q   [2][$];
  logic [7:0]  exp_line_q [2][$];
  int          dv_cnt [2] = '{0, 0};
  logic [7:0]  last_byte [2] = '{8'h0, 8'h0};
  logic        prev_dv [2] = '{1'b0, 1'b0};

  int          tx_st [2] = '{0, 0};
  int          tx_cnt [2] = '{0, 0};
  int          tx_bit [2] = '{0, 0};
  logic [9:0]  tx_sh [2];
  logic        dec_busy [2] = '{1'b0, 1'b0};
  int          dec_cnt [2] = '{0, 0};
  logic [7:0]  dec_sh [2];

  always #5 clk = ~clk;

  uart_hex_tx_sequencer #(.NUM_NIBBLES(8), .APPEND_CRLF(1)) u_dut0 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Start(start[0]), .i_Data(data0),
    .i_Tx_Active(tx_active[0]), .i_Tx_Done(tx_done[0]),
    .o_Tx_DV(tx_dv0), .o_Tx_Byte(tx_byte0), .o_Busy(busy0), .o_Done(done0));

  uart_hex_tx_sequencer #(.NUM_NIBBLES(2), .APPEND_CRLF(0)) u_dut1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Start(start[1]), .i_Data(data1),
    .i_Tx_Active(tx_active[1]), .i_Tx_Done(tx_done[1]),
    .o_Tx_DV(tx_dv1), .o_Tx_Byte(tx_byte1), .o_Busy(busy1), .o_Done(done1));

  function automatic logic dv_of(input int c);
    return (c == 0) ? tx_dv0 : tx_dv1;
  endfunction
  function automatic logic [7:0] byte_of(input int c);
    return (c == 0) ? tx_byte0 : tx_byte1;
  endfunction
  function automatic logic busy_of(input int c);
    return (c == 0) ? busy0 : busy1;
  endfunction
  function automatic logic done_of(input int c);
    return (c == 0) ? done0 : done1;
  endfunction
  function automatic int nibbles_of(input int c);
    return (c == 0) ? 8 : 2;
  endfunction
  function automatic int nchars_of(input int c);
    return (c == 0) ? 10 : 2;
  endfunction

  function automatic logic [7:0] ascii_hex(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
  endfunction

  function automatic logic [7:0] first_char(input int c, input logic [63:0] d);
    return ascii_hex(int'((d >> (4 * (nibbles_of(c) - 1))) & 64'hF));
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_word(input int c, input logic [63:0] d);
    for (int k = 0; k < nibbles_of(c); k++)
      exp_dv_q[c].push_back(ascii_hex(int'((d >> (4 * (nibbles_of(c) - 1 - k))) & 64'hF)));
    if (c == 0) begin
      exp_dv_q[c].push_back(8'h0D);
      exp_dv_q[c].push_back(8'h0A);
    end
  endtask

  task automatic set_data(input int c, input logic [63:0] d);
    if (c == 0) data0 = d[31:0];
    else        data1 = d[7:0];
  endtask

  task automatic line_check(input int c, input logic [7:0] b);
    check_eq("line_expected", 64'(exp_line_q[c].size() > 0), 64'd1);
    if (exp_line_q[c].size() > 0) check_eq("line_byte", b, exp_line_q[c].pop_front());
  endtask

  // Behavioural 8N1 transmitter: done stays high for two cycles, no reset input.
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      case (tx_st[c])
        0: begin
          tx_done[c]   <= 1'b0;
          tx_active[c] <= 1'b0;
          if (dv_of(c)) begin
            tx_sh[c]     <= {1'b1, byte_of(c), 1'b0};
            tx_bit[c]    <= 0;
            tx_cnt[c]    <= 0;
            tx_active[c] <= 1'b1;
            tx_serial[c] <= 1'b0;
            tx_st[c]     <= 1;
          end
        end
        1: begin
          if (tx_cnt[c] == CPB - 1) begin
            tx_cnt[c] <= 0;
            if (tx_bit[c] == 9) begin
              tx_st[c]     <= 2;
              tx_done[c]   <= 1'b1;
              tx_active[c] <= 1'b0;
              tx_serial[c] <= 1'b1;
            end else begin
              tx_bit[c]    <= tx_bit[c] + 1;
              tx_serial[c] <= tx_sh[c][tx_bit[c] + 1];
            end
          end else begin
            tx_cnt[c] <= tx_cnt[c] + 1;
          end
        end
        default: begin
          tx_done[c] <= 1'b1;
          tx_st[c]   <= 0;
        end
      endcase
    end
  end

  // Serial line decoder: samples each bit shortly after its start.
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!dec_busy[c]) begin
        if (tx_serial[c] == 1'b0) begin
          dec_busy[c] <= 1'b1;
          dec_cnt[c]  <= 0;
        end
      end else begin
        dec_cnt[c] <= dec_cnt[c] + 1;
        for (int j = 0; j < 8; j++)
          if (dec_cnt[c] == CPB * (j + 1) + 1) dec_sh[c][j] <= tx_serial[c];
        if (dec_cnt[c] == CPB * 9 + 1) begin
          dec_busy[c] <= 1'b0;
          line_check(c, dec_sh[c]);
        end
      end
    end
  end

  // Output monitor: every DV pulse and o_Done pulse is checked against the model.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        dv_cnt[c]    <= 0;
        last_byte[c] <= 8'h00;
        prev_dv[c]   <= 1'b0;
        exp_dv_q[c].delete();
      end else begin
        if (dv_of(c)) begin
          check_eq("dv_while_tx_busy", {tx_active[c], tx_done[c]}, 64'd0);
          check_eq("dv_one_cycle", prev_dv[c], 64'd0);
          check_eq("busy_at_dv", busy_of(c), 64'd1);
          check_eq("dv_expected", 64'(exp_dv_q[c].size() > 0), 64'd1);
          if (exp_dv_q[c].size() > 0) begin
            logic [7:0] e;
            e = exp_dv_q[c].pop_front();
            check_eq("tx_byte", byte_of(c), e);
            exp_line_q[c].push_back(e);
            last_byte[c] <= e;
          end else begin
            last_byte[c] <= byte_of(c);
          end
          dv_cnt[c] <= dv_cnt[c] + 1;
        end else begin
          check_eq("byte_hold", byte_of(c), last_byte[c]);
        end
        if (done_of(c)) begin
          check_eq("chars_per_word", dv_cnt[c], nchars_of(c));
          check_eq("busy_at_done", busy_of(c), 64'd0);
          check_eq("queue_at_done", exp_dv_q[c].size(), 64'd0);
          dv_cnt[c] <= 0;
        end
        prev_dv[c] <= dv_of(c);
      end
    end
  end

  task automatic start_word(input int c, input logic [63:0] d, input bit chk_lat, input bit hold);
    @(negedge clk);
    start[c] = 1'b1;
    set_data(c, d);
    push_word(c, d);
    @(negedge clk);
    if (!hold) start[c] = 1'b0;
    check_eq("busy_after_start", busy_of(c), 64'd1);
    if (chk_lat) check_eq("dv_latency_k", dv_of(c), 64'd0);
    @(negedge clk);
    if (chk_lat) begin
      check_eq("dv_latency_k1", dv_of(c), 64'd1);
      check_eq("first_byte", byte_of(c), first_char(c, d));
    end
  endtask

  task automatic wait_done(input int c, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done_of(c)) got = 1'b1;
    end
    check_eq("done_timeout", got, 64'd1);
  endtask

  task automatic wait_dv_count(input int c, input int n, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (dv_cnt[c] >= n) got = 1'b1;
    end
    check_eq("dv_count_timeout", got, 64'd1);
  endtask

  task automatic junk_pulse(input int c, input logic [63:0] d);
    @(negedge clk);
    start[c] = 1'b1;
    set_data(c, d);
    @(negedge clk);
    start[c] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      check_eq("reset_dv", dv_of(c), 64'd0);
      check_eq("reset_byte", byte_of(c), 64'd0);
      check_eq("reset_busy", busy_of(c), 64'd0);
      check_eq("reset_done", done_of(c), 64'd0);
    end
    rst_n = 1'b1;

    start_word(0, 64'h10000000, 1'b1, 1'b0);
    wait_done(0, 2000);
    start_word(0, 64'h1234ABCD, 1'b1, 1'b0);
    wait_done(0, 2000);
    start_word(1, 64'hF0, 1'b1, 1'b0);
    wait_done(1, 1000);
    repeat (20) @(negedge clk);

    // A second request and a data change during the third character are ignored.
    start_word(0, 64'h0, 1'b1, 1'b0);
    wait_dv_count(0, 3, 1000);
    junk_pulse(0, 64'hFFFFFFFF);
    wait_done(0, 2000);
    repeat (60) @(negedge clk);

    // Start held high: back-to-back words.
    start_word(0, 64'hA, 1'b1, 1'b1);
    for (int w = 0; w < 3; w++) begin
      wait_done(0, 2000);
      if (w < 2) begin
        @(posedge clk);
        push_word(0, 64'hA);
      end else begin
        start[0] = 1'b0;
      end
    end
    repeat (10) @(negedge clk);

    // Reset in the middle of the fifth character's frame.
    start_word(0, 64'h5A5A1234, 1'b1, 1'b0);
    wait_dv_count(0, 5, 2000);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_dv", tx_dv0, 64'd0);
    check_eq("midrst_byte", tx_byte0, 64'd0);
    check_eq("midrst_busy", busy0, 64'd0);
    check_eq("midrst_done", done0, 64'd0);
    check_eq("midrst_tx_still_active", tx_active[0], 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_word(0, 64'h9, 1'b0, 1'b0);
    wait_done(0, 2000);

    for (int w = 0; w < 6; w++) begin
      for (int c = 0; c < 2; c++) begin
        d = {$urandom(), $urandom()};
        repeat ($urandom_range(0, 4)) @(negedge clk);
        start_word(c, d, 1'b1, 1'b0);
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(3, 40)) @(negedge clk);
          junk_pulse(c, {$urandom(), $urandom()});
        end
        wait_done(c, 3000);
        if ($urandom_range(0, 2) == 0) begin
          start[c] = 1'b1;
          set_data(c, {$urandom(), $urandom()});
          @(negedge clk);
          start[c] = 1'b0;
        end
      end
    end

    repeat (100) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      check_eq("dv_queue_empty", exp_dv_q[c].size(), 64'd0);
      check_eq("line_queue_empty", exp_line_q[c].size(), 64'd0);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
